comparador_serial_ctrl: RTL

- Sequencer for the bit-serial magnitude comparator cell (next-state X = A·B' + x·B' + x·A).
- Captures two WIDTH-bit operands on a start pulse, then feeds one bit pair per clock, starting at the LSB (right-to-left) or the MSB (left-to-right).
- Publishes the active-low "A greater than B" flag Z plus an equality flag, with a start/busy/done handshake.
- Sits between the operand registers and the display/decision logic of the comparator project.

---
 rtl/comparador_serial_ctrl_if.sv | 27 ++
 rtl/comparador_serial_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/comparador_serial_ctrl_if.sv
// Handshake and operand bus for the bit-serial comparator sequencer.
//   start, dir, A, B : request side, driven by the operand/requester logic (master)
//   busy, done, Z, eq, bit_idx : status/result side, driven by the sequencer (slave)
interface comparador_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
);
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             Z;
  logic             eq;
  logic [IDXW-1:0]  bit_idx;

  modport master (
    output start, dir, A, B,
    input  busy, done, Z, eq, bit_idx
  );

  modport slave (
    input  start, dir, A, B,
    output busy, done, Z, eq, bit_idx
  );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Sequencer for the bit-serial magnitude comparator cell.
// Captures A/B/dir on an accepted start, then evaluates one bit pair per clock,
// LSB first (dir=0, recurrence X = a&~b | x&~b | x&a) or MSB first (dir=1,
// first differing bit decides). Publishes active-low "A > B" flag Z and eq.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of comparador_serial_ctrl_if
//           (start/dir/A/B in; busy/done/Z/eq/bit_idx out, all registered)
module comparador_serial_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input logic                      clk,
  input logic                      reset,
  comparador_serial_ctrl_if.slave  bus
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic             dir_sh_q;
  logic             x_q, gt_q, lt_q, eq_acc_q;
  logic [IDXW-1:0]  count_q, bit_idx_q;
  logic             busy_q, done_q, z_q, eq_q;

  logic a_bit, b_bit;
  logic x_d, gt_d, lt_d, eq_acc_d;

  // Next values of the accumulators for the bit pair under evaluation. The
  // final result registers sample these directly so Z/eq are valid in DONE.
  always_comb begin
    a_bit    = a_sh_q[bit_idx_q];
    b_bit    = b_sh_q[bit_idx_q];
    x_d      = (a_bit & ~b_bit) | (x_q & ~b_bit) | (x_q & a_bit);
    gt_d     = gt_q;
    lt_d     = lt_q;
    // MSB first: the first differing bit freezes the verdict.
    if (!gt_q && !lt_q) begin
      gt_d = a_bit & ~b_bit;
      lt_d = ~a_bit & b_bit;
    end
    eq_acc_d = eq_acc_q & ~(a_bit ^ b_bit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      dir_sh_q  <= 1'b0;
      x_q       <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_acc_q  <= 1'b0;
      count_q   <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      z_q       <= 1'b1;
      eq_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q    <= bus.A;
            b_sh_q    <= bus.B;
            dir_sh_q  <= bus.dir;
            x_q       <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_acc_q  <= 1'b1;
            count_q   <= '0;
            bit_idx_q <= bus.dir ? LastIdx : '0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          x_q      <= x_d;
          gt_q     <= gt_d;
          lt_q     <= lt_d;
          eq_acc_q <= eq_acc_d;
          count_q  <= count_q + IDXW'(1);
          if (count_q == LastIdx) begin
            // Final bit: bit_idx stays at its end point instead of wrapping.
            state_q <= StDone;
            done_q  <= 1'b1;
            z_q     <= dir_sh_q ? ~gt_d : ~x_d;
            eq_q    <= eq_acc_d;
          end else if (dir_sh_q) begin
            bit_idx_q <= bit_idx_q - IDXW'(1);
          end else begin
            bit_idx_q <= bit_idx_q + IDXW'(1);
          end
        end
        StDone: begin
          // start is deliberately ignored here; it is not queued.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Z       = z_q;
  assign bus.eq      = eq_q;
  assign bus.bit_idx = bit_idx_q;

endmodule
